multicycle_controller: RTL

Finite-state sequencer for the multi-cycle RV32I core. It steps the shared datapath (one ALU, one unified instruction/data memory, one instruction register) through fetch, decode, execute, memory and writeback, one state per clock. It replaces the single-cycle decode-and-branch logic. It decodes the ALU operation internally from `op`, `funct3` and `funct7_5`. It stalls on a ready/acknowledge signal from the memory port.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
//------------------------------------------------------------------------------
// Module      : multicycle_controller_if
// Description : Control bundle between the multi-cycle sequencer and datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;

    // The sequencer is the master: it consumes datapath status, drives enables.
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               illegal_op
    );

    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// Module      : multicycle_controller
// Description : FSM sequencer stepping the shared RV32I datapath one state/clk.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller (
    input wire                      clk,
    input wire                      rst_n,
    multicycle_controller_if.master ctrl
);

    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_MEMADR   = 4'd2;
    localparam logic [3:0] c_ST_MEMREAD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB    = 4'd4;
    localparam logic [3:0] c_ST_MEMWRITE = 4'd5;
    localparam logic [3:0] c_ST_EXECR    = 4'd6;
    localparam logic [3:0] c_ST_EXECI    = 4'd7;
    localparam logic [3:0] c_ST_ALUWB    = 4'd8;
    localparam logic [3:0] c_ST_BEQ      = 4'd9;
    localparam logic [3:0] c_ST_JAL      = 4'd10;
    localparam logic [3:0] c_ST_HALT     = 4'd11;

    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    localparam logic [1:0] c_ALUOP_ADD  = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB  = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNC = 2'b10;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_imm_src;
    logic [2:0] w_alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_alu_op     = c_ALUOP_ADD;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;

        case (r_state)
            c_ST_FETCH: begin
                // PC+4 is computed alongside the fetch and loaded with the IR.
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = ctrl.mem_ready;
                w_pc_write   = ctrl.mem_ready;
                if (ctrl.mem_ready) begin
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                // OldPC + imm: branch/jump target lands in ALUOut for BEQ.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (ctrl.op)
                    c_OP_LW,
                    c_OP_SW:    w_next_state = c_ST_MEMADR;
                    c_OP_RTYPE: w_next_state = c_ST_EXECR;
                    c_OP_ITYPE: w_next_state = c_ST_EXECI;
                    c_OP_BEQ:   w_next_state = c_ST_BEQ;
                    c_OP_JAL:   w_next_state = c_ST_JAL;
                    default:    w_next_state = c_ST_HALT;
                endcase
            end
            c_ST_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = ctrl.op[5] ? c_ST_MEMWRITE : c_ST_MEMREAD;
            end
            c_ST_MEMREAD: begin
                w_adr_src = 1'b1;
                if (ctrl.mem_ready) begin
                    w_next_state = c_ST_MEMWB;
                end
            end
            c_ST_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (ctrl.mem_ready) begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_EXECR: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = c_ALUOP_FUNC;
                w_next_state = c_ST_ALUWB;
            end
            c_ST_EXECI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_op     = c_ALUOP_FUNC;
                w_next_state = c_ST_ALUWB;
            end
            c_ST_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_BEQ: begin
                // ALUOut still holds the target from DECODE while rs1-rs2 sets zero.
                w_alu_src_a  = 2'b10;
                w_alu_op     = c_ALUOP_SUB;
                w_pc_write   = ctrl.zero;
                w_next_state = c_ST_FETCH;
            end
            c_ST_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = c_ST_ALUWB;
            end
            c_ST_HALT: begin
                w_next_state = c_ST_HALT;
            end
            default: begin
                // Unused encodings recover through a fresh fetch.
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    always_comb begin
        w_alu_control = c_ALU_ADD;
        case (w_alu_op)
            c_ALUOP_SUB: w_alu_control = c_ALU_SUB;
            c_ALUOP_FUNC: begin
                case (ctrl.funct3)
                    3'b000:  w_alu_control = (ctrl.op[5] & ctrl.funct7_5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  w_alu_control = c_ALU_SLT;
                    3'b110:  w_alu_control = c_ALU_OR;
                    3'b111:  w_alu_control = c_ALU_AND;
                    default: w_alu_control = c_ALU_ADD;
                endcase
            end
            default: w_alu_control = c_ALU_ADD;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (ctrl.op)
            c_OP_SW:  w_imm_src = 2'b01;
            c_OP_BEQ: w_imm_src = 2'b10;
            c_OP_JAL: w_imm_src = 2'b11;
            default:  w_imm_src = 2'b00;
        endcase
    end

    assign ctrl.pc_write    = w_pc_write;
    assign ctrl.adr_src     = w_adr_src;
    assign ctrl.mem_write   = w_mem_write;
    assign ctrl.ir_write    = w_ir_write;
    assign ctrl.reg_write   = w_reg_write;
    assign ctrl.result_src  = w_result_src;
    assign ctrl.alu_src_a   = w_alu_src_a;
    assign ctrl.alu_src_b   = w_alu_src_b;
    assign ctrl.imm_src     = w_imm_src;
    assign ctrl.alu_control = w_alu_control;
    assign ctrl.illegal_op  = (r_state == c_ST_HALT);

endmodule

`default_nettype wire
